// File: rtl/fft_pkg.sv
// Shared definitions for the 1024-point radix-2 DIT FFT core.
// Holds the FFT size constants, the default butterfly write-back latency,
// the address/stage types and the address sequencer state enum.
package fft_pkg;

    localparam int unsigned LOG2_N     = 10;
    localparam int unsigned N          = 1 << LOG2_N;
    localparam int unsigned NUM_BF     = N / 2;
    localparam int unsigned BF_LATENCY = 4;

    typedef logic [LOG2_N-1:0] fft_addr_t;
    typedef logic [LOG2_N-2:0] tw_addr_t;
    typedef logic [3:0]        stage_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } fsm_state_e;

endpackage

// File: rtl/fft_bf_addr.sv
// Combinational butterfly address map for one radix-2 DIT stage.
// Ports:
//   i_stage   - stage index s, 0..LOG2_N-1
//   i_bf_idx  - butterfly index j within the stage
//   o_addr_a  - top operand address A
//   o_addr_b  - bottom operand address B = A + 2^s
//   o_tw_addr - twiddle ROM index k
module fft_bf_addr
    import fft_pkg::*;
(
    input  stage_t    i_stage,
    input  tw_addr_t  i_bf_idx,
    output fft_addr_t o_addr_a,
    output fft_addr_t o_addr_b,
    output tw_addr_t  o_tw_addr
);

    fft_addr_t w_j;
    fft_addr_t w_half;
    fft_addr_t w_pos;
    fft_addr_t w_grp;
    fft_addr_t w_tw_full;
    stage_t    w_tw_shift;

    assign w_j    = {1'b0, i_bf_idx};
    assign w_half = fft_addr_t'(1) << i_stage;
    assign w_pos  = w_j & (w_half - fft_addr_t'(1));
    assign w_grp  = w_j >> i_stage;

    // Insert a zero bit at position s: the group index moves up past the B-half.
    assign o_addr_a = (w_grp << (i_stage + stage_t'(1))) | w_pos;
    assign o_addr_b = o_addr_a + w_half;

    // pos < 2^s, so pos << (LOG2_N-1-s) always fits the 9-bit ROM index.
    assign w_tw_shift = stage_t'(LOG2_N - 1) - i_stage;
    assign w_tw_full  = w_pos << w_tw_shift;
    assign o_tw_addr  = tw_addr_t'(w_tw_full);

endmodule

// File: rtl/fft_addr_gen.sv
// Address and twiddle sequencer for the radix-2 DIT FFT.
// Walks all stages x butterflies after a start pulse, driving the twiddle ROM
// read port each RUN cycle and, one cycle later (aligned with ROM data), the
// butterfly operand addresses. A drain gap between stages lets write-back land.
// Ports:
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   i_start        - start pulse, only honoured in IDLE
//   i_stall        - back-pressure, freezes sequencing while in RUN
//   o_busy, o_done - status; o_done pulses once when the last stage drained
//   o_tw_rd_en, o_tw_addr - twiddle ROM read port
//   o_bf_valid, o_addr_a, o_addr_b, o_stage - butterfly beat, ROM-aligned
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int unsigned LOG2_N     = fft_pkg::LOG2_N,
    parameter int unsigned BF_LATENCY = fft_pkg::BF_LATENCY
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_start,
    input  logic      i_stall,
    output logic      o_busy,
    output logic      o_done,
    output logic      o_tw_rd_en,
    output tw_addr_t  o_tw_addr,
    output logic      o_bf_valid,
    output fft_addr_t o_addr_a,
    output fft_addr_t o_addr_b,
    output stage_t    o_stage
);

    localparam int unsigned DRAIN_W = $clog2(BF_LATENCY + 2);
    localparam stage_t      LAST_STAGE = stage_t'(LOG2_N - 1);
    localparam tw_addr_t    LAST_BF    = tw_addr_t'(NUM_BF - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(BF_LATENCY);

    fsm_state_e          r_state, w_state_d;
    stage_t              r_stage, w_stage_d;
    tw_addr_t            r_bf_idx, w_bf_idx_d;
    logic [DRAIN_W-1:0]  r_drain_cnt, w_drain_cnt_d;

    logic      w_issue;
    fft_addr_t w_addr_a;
    fft_addr_t w_addr_b;
    tw_addr_t  w_tw_addr;

    logic      r_bf_valid;
    fft_addr_t r_addr_a;
    fft_addr_t r_addr_b;
    stage_t    r_bf_stage;

    fft_bf_addr u_bf_addr (
        .i_stage   (r_stage),
        .i_bf_idx  (r_bf_idx),
        .o_addr_a  (w_addr_a),
        .o_addr_b  (w_addr_b),
        .o_tw_addr (w_tw_addr)
    );

    assign w_issue = (r_state == StRun) && !i_stall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_stage     <= '0;
            r_bf_idx    <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_d;
            r_stage     <= w_stage_d;
            r_bf_idx    <= w_bf_idx_d;
            r_drain_cnt <= w_drain_cnt_d;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_stage_d     = r_stage;
        w_bf_idx_d    = r_bf_idx;
        w_drain_cnt_d = r_drain_cnt;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_d  = StRun;
                    w_stage_d  = '0;
                    w_bf_idx_d = '0;
                end
            end
            StRun: begin
                if (!i_stall) begin
                    if (r_bf_idx == LAST_BF) begin
                        w_state_d     = StDrain;
                        w_bf_idx_d    = '0;
                        w_drain_cnt_d = '0;
                    end else begin
                        w_bf_idx_d = r_bf_idx + tw_addr_t'(1);
                    end
                end
            end
            StDrain: begin
                // Counts 0..BF_LATENCY, i.e. BF_LATENCY+1 cycles; stall is ignored.
                if (r_drain_cnt == DRAIN_LAST) begin
                    if (r_stage == LAST_STAGE) begin
                        w_state_d = StDone;
                    end else begin
                        w_state_d  = StRun;
                        w_stage_d  = r_stage + stage_t'(1);
                        w_bf_idx_d = '0;
                    end
                end else begin
                    w_drain_cnt_d = r_drain_cnt + DRAIN_W'(1);
                end
            end
            StDone: begin
                w_state_d  = StIdle;
                w_stage_d  = '0;
                w_bf_idx_d = '0;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Beat register: one cycle behind the ROM read, so it lines up with rd_data.
    // Addresses only load on an issued beat so idle outputs stay at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bf_valid <= 1'b0;
            r_addr_a   <= '0;
            r_addr_b   <= '0;
            r_bf_stage <= '0;
        end else begin
            r_bf_valid <= w_issue;
            if (w_issue) begin
                r_addr_a   <= w_addr_a;
                r_addr_b   <= w_addr_b;
                r_bf_stage <= r_stage;
            end
        end
    end

    assign o_busy     = (r_state != StIdle);
    assign o_done     = (r_state == StDone);
    assign o_tw_rd_en = (r_state == StRun);
    assign o_tw_addr  = (r_state == StRun) ? w_tw_addr : '0;
    assign o_bf_valid = r_bf_valid;
    assign o_addr_a   = r_addr_a;
    assign o_addr_b   = r_addr_b;
    assign o_stage    = r_bf_stage;

endmodule

// File: tb/tb_fft_addr_gen.sv
// Self-checking bench for fft_addr_gen: a beat-index reference model predicts
// every output each cycle; scoreboards check per-stage address coverage, beat
// count, drain gaps and the o_done cycle for plain, stalled and random runs.
module tb_fft_addr_gen;

    localparam int BF_LAT     = 4;
    localparam int STAGES     = 10;
    localparam int NBF        = 512;
    localparam int BEATS      = STAGES * NBF;
    localparam int DONE_CYCLE = 1 + STAGES * (NBF + BF_LAT + 1);

    logic       i_clk   = 1'b0;
    logic       i_rst_n = 1'b1;
    logic       i_start = 1'b0;
    logic       i_stall = 1'b0;
    logic       o_busy, o_done, o_tw_rd_en, o_bf_valid;
    logic [8:0] o_tw_addr;
    logic [9:0] o_addr_a, o_addr_b;
    logic [3:0] o_stage;

    fft_addr_gen #(
        .LOG2_N     (10),
        .BF_LATENCY (BF_LAT)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_stall    (i_stall),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_tw_rd_en (o_tw_rd_en),
        .o_tw_addr  (o_tw_addr),
        .o_bf_valid (o_bf_valid),
        .o_addr_a   (o_addr_a),
        .o_addr_b   (o_addr_b),
        .o_stage    (o_stage)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    // Reference address math with division/modulo.
    function automatic int ref_a(input int s, input int j);
        int half = 1 << s;
        return (j / half) * 2 * half + (j % half);
    endfunction
    function automatic int ref_b(input int s, input int j);
        return ref_a(s, j) + (1 << s);
    endfunction
    function automatic int ref_k(input int s, input int j);
        int half = 1 << s;
        return (j % half) * (NBF / half);
    endfunction

    // Model: mode 0 idle, 1 run, 2 drain, 3 done; m_idx = next global beat.
    int m_mode = 0, m_idx = 0, m_gap = 0, m_vidx = 0;
    bit m_vld  = 1'b0;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_mode <= 0; m_idx <= 0; m_gap <= 0; m_vidx <= 0; m_vld <= 1'b0;
        end else begin
            m_vld <= (m_mode == 1) && !i_stall;
            if (m_mode == 1 && !i_stall) m_vidx <= m_idx;
            case (m_mode)
                0: if (i_start) begin m_mode <= 1; m_idx <= 0; end
                1: if (!i_stall) begin
                    m_idx <= m_idx + 1;
                    if (m_idx % NBF == NBF - 1) begin m_mode <= 2; m_gap <= 1; end
                end
                2: if (m_gap == BF_LAT + 1) m_mode <= (m_idx == BEATS) ? 3 : 1;
                   else m_gap <= m_gap + 1;
                default: m_mode <= 0;
            endcase
        end
    end

    int seen [STAGES][1024];
    int stage_beats [STAGES];
    int beats     = 0;
    int drain_len = 0;

    // Per-cycle compare, sampled on the falling edge.
    initial begin
        int s, j, sj;
        forever begin
            @(negedge i_clk);
            chk("busy", o_busy, int'(m_mode != 0));
            chk("done", o_done, int'(m_mode == 3));
            chk("tw_rd_en", o_tw_rd_en, int'(m_mode == 1));
            chk("tw_addr", o_tw_addr, (m_mode == 1) ? ref_k(m_idx / NBF, m_idx % NBF) : 0);
            chk("bf_valid", o_bf_valid, int'(m_vld));
            if (m_vld) begin
                s = m_vidx / NBF;
                j = m_vidx % NBF;
                chk("addr_a", o_addr_a, ref_a(s, j));
                chk("addr_b", o_addr_b, ref_b(s, j));
                chk("stage", o_stage, s);
            end
            if (o_bf_valid && o_stage < STAGES) begin
                seen[o_stage][o_addr_a]++;
                seen[o_stage][o_addr_b]++;
                beats++;
                sj = stage_beats[o_stage];
                if (o_stage == 0 && sj == 0) begin
                    chk("s0j0_a", o_addr_a, 0); chk("s0j0_b", o_addr_b, 1);
                end
                if (o_stage == 0 && sj == 5) begin
                    chk("s0j5_a", o_addr_a, 10); chk("s0j5_b", o_addr_b, 11);
                end
                if (o_stage == 3 && sj == 13) begin
                    chk("s3j13_a", o_addr_a, 21); chk("s3j13_b", o_addr_b, 29);
                end
                if (o_stage == 9 && sj == 511) begin
                    chk("s9j511_a", o_addr_a, 511); chk("s9j511_b", o_addr_b, 1023);
                end
                stage_beats[o_stage]++;
            end
            // Busy with no ROM read and no done pulse is a drain cycle.
            if (!o_busy) drain_len = 0;
            else if (o_tw_rd_en || o_done) begin
                if (drain_len != 0 || o_done) chk("drain_len", drain_len, BF_LAT + 1);
                drain_len = 0;
            end else drain_len++;
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_rd_en"}, o_tw_rd_en, 0);
        chk({tag, "_tw_addr"}, o_tw_addr, 0);
        chk({tag, "_valid"}, o_bf_valid, 0);
        chk({tag, "_addr_a"}, o_addr_a, 0);
        chk({tag, "_addr_b"}, o_addr_b, 0);
        chk({tag, "_stage"}, o_stage, 0);
    endtask

    // kind 0: unstalled, stray start mid-run; 1: 3-cycle stall; 2: random.
    task automatic run_fft(input int kind);
        int c, stalls, ok;
        bit got;
        for (int s = 0; s < STAGES; s++) begin
            stage_beats[s] = 0;
            for (int a = 0; a < 1024; a++) seen[s][a] = 0;
        end
        beats  = 0;
        stalls = 0;
        got    = 1'b0;
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        c = 1;
        while (c < DONE_CYCLE + 2000) begin
            if (o_done) begin got = 1'b1; break; end
            i_stall = 1'b0;
            i_start = 1'b0;
            case (kind)
                0: if (c == 300) i_start = 1'b1;
                // Stage 2 RUN starts at cycle 1035; j=101 (k=128) is issued at 1136.
                1: if (c >= 1136 && c <= 1138) begin
                    i_stall = 1'b1;
                    chk("stall_tw_addr", o_tw_addr, 128);
                end
                default: begin
                    i_stall = ($urandom_range(0, 7) == 0);
                    i_start = ($urandom_range(0, 63) == 0);
                end
            endcase
            if (i_stall && m_mode == 1) stalls++;
            @(negedge i_clk);
            c++;
        end
        i_stall = 1'b0;
        i_start = 1'b0;
        chk("done_seen", int'(got), 1);
        case (kind)
            0:       chk("done_cycle", c, 5171);
            1:       chk("done_cycle_stall", c, 5174);
            default: chk("done_cycle_rand", c, DONE_CYCLE + stalls);
        endcase
        @(negedge i_clk);
        chk("busy_after_done", o_busy, 0);
        chk("beat_count", beats, BEATS);
        for (int s = 0; s < STAGES; s++) begin
            ok = 1;
            for (int a = 0; a < 1024; a++) if (seen[s][a] != 1) ok = 0;
            chk($sformatf("stage%0d_cover", s), ok, 1);
        end
    endtask

    initial begin
        #1 i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        check_all_zero("in_reset");
        i_rst_n = 1'b1;
        repeat (20) @(negedge i_clk);
        check_all_zero("idle");

        chk("pin_k_s0j5", ref_k(0, 5), 0);
        chk("pin_k_s3j13", ref_k(3, 13), 320);
        chk("pin_k_s9j511", ref_k(9, 511), 511);
        chk("pin_k_s2j101", ref_k(2, 101), 128);
        chk("pin_a_s3j13", ref_a(3, 13), 21);

        run_fft(0);
        run_fft(1);
        run_fft(2);

        // Reset mid-run: busy must drop without waiting for a clock edge.
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (700) @(negedge i_clk);
        @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        chk("rst_busy", o_busy, 0);
        chk("rst_rd_en", o_tw_rd_en, 0);
        chk("rst_valid", o_bf_valid, 0);
        chk("rst_tw_addr", o_tw_addr, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (10) @(negedge i_clk);
        check_all_zero("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
